alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops, bit-serial shifts and rotates.
// result/flags are registered and change only on the edge that enters DONE.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       sop_q, sop_d;   // {opcode[3], opcode[1:0]} of the shift in flight
   logic [WIDTH-1:0] wk_q, wk_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       flg_q, flg_d;

   // One shift/rotate step; returns {bit shifted out, new value}.
   function automatic logic [WIDTH:0] step1(input logic [2:0] sop, input logic [WIDTH-1:0] v);
      logic [WIDTH:0] r;
      case (sop[1:0])
         2'b00:   r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         2'b01:   r = {v[0], (sop[2] & v[WIDTH-1]), v[WIDTH-1:1]};
         2'b10:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         default: r = {v[0], v[0], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   function automatic logic [3:0] mkflg(input logic [WIDTH-1:0] r, input logic v, input logic c);
      return {~|r, r[WIDTH-1], v, c};
   endfunction

   logic [WIDTH-1:0] bop;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_v, alu_c;
   logic [SHW-1:0]   k;
   logic [WIDTH:0]   stp;

   always_comb begin
      bop   = opcode[3] ? ~b : b;
      sum   = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, opcode[3]};
      alu_v = 1'b0;
      alu_c = 1'b0;
      case (opcode[1:0])
         2'b00: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         2'b01:   alu_res = a ^ b;
         2'b10:   alu_res = a & b;
         default: alu_res = opcode[3] ? ~(a | b) : (a | b);
      endcase
   end

   assign k   = b[SHW-1:0];
   // The first step is taken from the live inputs on the start edge.
   assign stp = (state_q == IDLE) ? step1({opcode[3], opcode[1:0]}, a) : step1(sop_q, wk_q);

   always_comb begin
      state_d = state_q;
      sop_d   = sop_q;
      wk_d    = wk_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      flg_d   = flg_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sop_d = {opcode[3], opcode[1:0]};
               if (!opcode[2]) begin
                  res_d   = alu_res;
                  flg_d   = mkflg(alu_res, alu_v, alu_c);
                  state_d = DONE;
               end else if (k == '0) begin
                  res_d   = a;
                  flg_d   = mkflg(a, 1'b0, 1'b0);
                  state_d = DONE;
               end else if (k == SHW'(1)) begin
                  res_d   = stp[WIDTH-1:0];
                  flg_d   = mkflg(stp[WIDTH-1:0], 1'b0, stp[WIDTH]);
                  state_d = DONE;
               end else begin
                  wk_d    = stp[WIDTH-1:0];
                  cnt_d   = k - SHW'(1);
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (cnt_q == SHW'(1)) begin
               res_d   = stp[WIDTH-1:0];
               flg_d   = mkflg(stp[WIDTH-1:0], 1'b0, stp[WIDTH]);
               state_d = DONE;
            end else begin
               wk_d  = stp[WIDTH-1:0];
               cnt_d = cnt_q - SHW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sop_q   <= '0;
         wk_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         sop_q   <= sop_d;
         wk_q    <= wk_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = res_q;
   assign flags  = flg_q;

endmodule
